// File: rtl/frame_line_reader.sv
// frame_line_reader: reads stored video frames from memory with AXI4 read
// bursts and streams them out as 64-bit AXI4-Stream, one packet per line.
// A write tracker follows the frame writer so that every new frame starts
// on the freshest complete slot. Each finished frame is released back to the
// writer through a 4-phase done/ack handshake.
//
// Handshake semantics (AR, R and the stream alike): a transfer happens on the
// rising clock edge where valid and ready are both 1. Once valid is raised,
// the payload stays stable until that edge. Ready may change freely.
module frame_line_reader #(
  parameter int unsigned START_ADDR    = 0,
  parameter int unsigned FRAMES_AMOUNT = 3,
  parameter int unsigned FRAME_RES_Y   = 1080,
  parameter int unsigned FRAME_RES_X   = 1920,
  parameter int unsigned BURST_LEN     = 16,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  // AXI4 read address channel
  output logic                  mem_rd_arvalid,
  input  logic                  mem_rd_arready,
  output logic [ADDR_WIDTH-1:0] mem_rd_araddr,
  output logic [7:0]            mem_rd_arlen,
  output logic [2:0]            mem_rd_arsize,
  output logic [1:0]            mem_rd_arburst,
  output logic [3:0]            mem_rd_arid,
  // AXI4 read data channel
  input  logic                  mem_rd_rvalid,
  output logic                  mem_rd_rready,
  input  logic [63:0]           mem_rd_rdata,
  input  logic [1:0]            mem_rd_rresp,
  input  logic                  mem_rd_rlast,
  // Write side of the memory port is never used
  output logic                  mem_rd_awvalid,
  output logic                  mem_rd_wvalid,
  output logic                  mem_rd_bready,
  // Video stream out, 4 pixels per beat
  output logic                  video_tvalid,
  input  logic                  video_tready,
  output logic [63:0]           video_tdata,
  output logic [7:0]            video_tkeep,
  output logic [7:0]            video_tstrb,
  output logic                  video_tlast,
  output logic                  video_tuser,
  // Frame ownership handshakes with the writer
  input  logic                  wr_done_i,
  output logic                  wr_done_ack_o,
  output logic                  rd_done_o,
  input  logic                  rd_done_ack_i,
  output logic                  err_o,
  // Main FSM state for observation
  output logic [2:0]            dbg_state
);

  localparam int unsigned LINE_BYTES      = FRAME_RES_X * 2;
  localparam int unsigned FRAME_BYTES     = LINE_BYTES * FRAME_RES_Y;
  localparam int unsigned BURST_BYTES     = BURST_LEN * 8;
  localparam int unsigned BURSTS_PER_LINE = LINE_BYTES / BURST_BYTES;
  localparam int unsigned SLOT_W  = (FRAMES_AMOUNT > 1)   ? $clog2(FRAMES_AMOUNT)   : 1;
  localparam int unsigned BURST_W = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
  localparam int unsigned LINE_W  = (FRAME_RES_Y > 1)     ? $clog2(FRAME_RES_Y)     : 1;

  localparam logic [ADDR_WIDTH-1:0] START_A       = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] FRAME_BYTES_A = ADDR_WIDTH'(FRAME_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES_A = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [SLOT_W-1:0]     LAST_SLOT     = SLOT_W'(FRAMES_AMOUNT - 1);
  localparam logic [BURST_W-1:0]    LAST_BURST    = BURST_W'(BURSTS_PER_LINE - 1);
  localparam logic [LINE_W-1:0]     LAST_LINE     = LINE_W'(FRAME_RES_Y - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL      = 3'd1,
    ADDR     = 3'd2,
    DATA     = 3'd3,
    DONE_REQ = 3'd4,
    DONE_REL = 3'd5
  } state_t;

  state_t                state_q, state_d;

  logic [SLOT_W-1:0]     wr_slot_q;
  logic [SLOT_W-1:0]     latest_slot_q;
  logic [SLOT_W-1:0]     cur_slot_q;
  logic                  fresh_q;
  logic                  ack_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [LINE_W-1:0]     line_q;
  logic [BURST_W-1:0]    burst_q;
  logic                  first_q;

  logic                  wr_take;
  logic                  sel_take_fresh;
  logic                  r_fire;
  logic                  last_burst;
  logic                  last_line;
  logic [SLOT_W-1:0]     sel_slot;
  logic [ADDR_WIDTH-1:0] frame_base;

  assign wr_take        = wr_done_i && !ack_q;
  assign sel_take_fresh = (state_q == SEL) && fresh_q;
  assign r_fire         = mem_rd_rvalid && mem_rd_rready;
  assign last_burst     = (burst_q == LAST_BURST);
  assign last_line      = (line_q == LAST_LINE);
  assign sel_slot       = fresh_q ? latest_slot_q : cur_slot_q;
  assign frame_base     = START_A + ADDR_WIDTH'(sel_slot) * FRAME_BYTES_A;

  // Write tracker: acknowledge writer frames and remember the freshest slot
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_slot_q     <= '0;
      latest_slot_q <= '0;
      fresh_q       <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      if (wr_take) begin
        ack_q         <= 1'b1;
        latest_slot_q <= wr_slot_q;
        wr_slot_q     <= (wr_slot_q == LAST_SLOT) ? '0 : wr_slot_q + SLOT_W'(1);
      end else if (!wr_done_i) begin
        ack_q <= 1'b0;
      end
      // A frame completing in the same cycle SEL consumes the flag keeps it set
      if (wr_take) begin
        fresh_q <= 1'b1;
      end else if (sel_take_fresh) begin
        fresh_q <= 1'b0;
      end
    end
  end

  // Main FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Main FSM next state and channel controls; the data path is pass-through
  always_comb begin
    state_d        = state_q;
    mem_rd_arvalid = 1'b0;
    mem_rd_rready  = 1'b0;
    video_tvalid   = 1'b0;
    video_tlast    = 1'b0;
    video_tuser    = 1'b0;
    rd_done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fresh_q) state_d = SEL;
      end
      SEL: begin
        state_d = ADDR;
      end
      ADDR: begin
        mem_rd_arvalid = 1'b1;
        if (mem_rd_arready) state_d = DATA;
      end
      DATA: begin
        mem_rd_rready = video_tready;
        video_tvalid  = mem_rd_rvalid;
        video_tuser   = first_q;
        video_tlast   = mem_rd_rlast && last_burst;
        if (r_fire && mem_rd_rlast) begin
          state_d = (last_burst && last_line) ? DONE_REQ : ADDR;
        end
      end
      DONE_REQ: begin
        rd_done_o = 1'b1;
        if (rd_done_ack_i) state_d = DONE_REL;
      end
      DONE_REL: begin
        if (!rd_done_ack_i) state_d = SEL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame position: slot choice, burst address, line/burst counters, error flag
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cur_slot_q <= '0;
      araddr_q   <= '0;
      line_q     <= '0;
      burst_q    <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == SEL) begin
        cur_slot_q <= sel_slot;
        araddr_q   <= frame_base;
        line_q     <= '0;
        burst_q    <= '0;
        first_q    <= 1'b1;
      end else if ((state_q == DATA) && r_fire) begin
        first_q <= 1'b0;
        if (mem_rd_rresp != 2'b00) err_q <= 1'b1;
        if (mem_rd_rlast) begin
          araddr_q <= araddr_q + BURST_BYTES_A;
          if (last_burst) begin
            burst_q <= '0;
            line_q  <= line_q + LINE_W'(1);
          end else begin
            burst_q <= burst_q + BURST_W'(1);
          end
        end
      end
    end
  end

  assign mem_rd_araddr  = araddr_q;
  assign mem_rd_arlen   = 8'(BURST_LEN - 1);
  assign mem_rd_arsize  = 3'd3;
  assign mem_rd_arburst = 2'b01;
  assign mem_rd_arid    = 4'd0;
  assign mem_rd_awvalid = 1'b0;
  assign mem_rd_wvalid  = 1'b0;
  assign mem_rd_bready  = 1'b1;

  assign video_tdata    = mem_rd_rdata;
  assign video_tkeep    = 8'hFF;
  assign video_tstrb    = 8'hFF;

  assign wr_done_ack_o  = ack_q;
  assign err_o          = err_q;
  assign dbg_state      = state_q;

endmodule
